// File: rtl/axis_byte_packer_pkg.sv
// Shared types for the AXI4-Stream byte packer.
// Holds only width-independent items; anything derived from DATA_WIDTH
// lives in the module that owns the parameter.
package axis_byte_packer_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/axi4s_if.sv
// Minimal AXI4-Stream interface.
//   aclk   : stream clock (driven by the master side)
//   tvalid : beat valid
//   tready : sink ready
//   tdata  : DATA_WIDTH payload, byte lane 0 in bits [7:0]
//   tkeep  : one bit per byte lane
//   tlast  : end of packet
// Modport m is the producer, modport s the consumer.
interface axi4s_if #(
  parameter int DATA_WIDTH = 64
);
  logic                    aclk;
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;

  modport m (output aclk, tvalid, tdata, tkeep, tlast, input tready);
  modport s (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_byte_packer_append.sv
// byte_append: combinational merge of the residue buffer with an incoming
// word. The first k_i lanes of word_i are placed directly above the cnt_i
// valid residue lanes; every lane above the merged data is forced to zero.
// Ports:
//   buf_i   : residue buffer, 2*BYTES lanes, lanes >= cnt_i ignored
//   cnt_i   : number of valid residue lanes
//   word_i  : incoming word
//   k_i     : number of valid lanes in word_i (contiguous from lane 0)
//   buf_o   : merged buffer
//   total_o : cnt_i + k_i
module byte_append #(
  parameter int BYTES = 8,
  parameter int CNT_W = 4
) (
  input  logic [2*BYTES*8-1:0] buf_i,
  input  logic [CNT_W-1:0]     cnt_i,
  input  logic [BYTES*8-1:0]   word_i,
  input  logic [CNT_W-1:0]     k_i,
  output logic [2*BYTES*8-1:0] buf_o,
  output logic [CNT_W-1:0]     total_o
);

  logic [2*BYTES*8-1:0] word_ext;
  logic [2*BYTES*8-1:0] res_kept;

  always_comb begin
    word_ext = '0;
    res_kept = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (CNT_W'(i) < k_i) word_ext[i*8 +: 8] = word_i[i*8 +: 8];
    end
    for (int j = 0; j < 2*BYTES; j++) begin
      if (CNT_W'(j) < cnt_i) res_kept[j*8 +: 8] = buf_i[j*8 +: 8];
    end
    buf_o = res_kept | (word_ext << {cnt_i, 3'b000});
  end

  assign total_o = cnt_i + k_i;

endmodule

// File: rtl/axis_byte_packer.sv
// Packs a sparsely filled AXI4-Stream into fully populated words. Only the
// final beat of a packet may be partial; each input tlast yields exactly one
// output tlast (possibly with tkeep = 0).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_data       : input stream (tkeep contiguous from lane 0)
//   o_data       : packed output stream, one register stage
//   packet_bytes : byte count of the most recently completed packet
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | accepting input; residue holds 0..BYTES-1 bytes
// FLUSH | tlast arrived with a full word plus residue; emit residue beat
module axis_byte_packer
  import axis_byte_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  axi4s_if.s          i_data,
  axi4s_if.m          o_data,
  output logic [31:0] packet_bytes
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(2 * BYTES);
  localparam int BUF_W = 2 * DATA_WIDTH;

  function automatic logic [CNT_W-1:0] popcount(input logic [BYTES-1:0] keep);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < BYTES; i++) n = n + CNT_W'(keep[i]);
    return n;
  endfunction

  function automatic logic [BYTES-1:0] keep_mask(input logic [CNT_W-1:0] n);
    logic [BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < BYTES; i++) m[i] = (CNT_W'(i) < n);
    return m;
  endfunction

  state_e                state_q, state_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           acc_q, acc_d;
  logic [31:0]           pb_q, pb_d;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_tdata_q, o_tdata_d;
  logic [BYTES-1:0]      o_tkeep_q, o_tkeep_d;
  logic                  o_tlast_q, o_tlast_d;

  logic                  slot_free;
  logic                  accept;
  logic [CNT_W-1:0]      k_in;
  logic [BUF_W-1:0]      merged;
  logic [CNT_W-1:0]      total;
  logic                  emit;
  logic [CNT_W-1:0]      emit_bytes;

  assign slot_free     = !o_valid_q || o_data.tready;
  assign i_data.tready = (state_q == RUN) && slot_free;
  assign accept        = i_data.tvalid && i_data.tready;
  assign k_in          = popcount(i_data.tkeep);

  byte_append #(
    .BYTES (BYTES),
    .CNT_W (CNT_W)
  ) u_append (
    .buf_i   (buf_q),
    .cnt_i   (cnt_q),
    .word_i  (i_data.tdata),
    .k_i     (k_in),
    .buf_o   (merged),
    .total_o (total)
  );

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    pb_d       = pb_q;
    o_valid_d  = o_valid_q && !o_data.tready;
    o_tdata_d  = o_tdata_q;
    o_tkeep_d  = o_tkeep_q;
    o_tlast_d  = o_tlast_q;
    emit       = 1'b0;
    emit_bytes = '0;

    case (state_q)
      RUN: begin
        if (accept) begin
          if (total >= CNT_W'(BYTES)) begin
            emit       = 1'b1;
            emit_bytes = CNT_W'(BYTES);
            o_tdata_d  = merged[DATA_WIDTH-1:0];
            o_tkeep_d  = '1;
            o_tlast_d  = i_data.tlast && (total == CNT_W'(BYTES));
            buf_d      = merged >> DATA_WIDTH;
            cnt_d      = total - CNT_W'(BYTES);
            if (i_data.tlast && (total != CNT_W'(BYTES))) state_d = FLUSH;
          end else if (i_data.tlast) begin
            // Short packet tail, including the empty tkeep=0 case.
            emit       = 1'b1;
            emit_bytes = total;
            o_tdata_d  = merged[DATA_WIDTH-1:0];
            o_tkeep_d  = keep_mask(total);
            o_tlast_d  = 1'b1;
            buf_d      = '0;
            cnt_d      = '0;
          end else begin
            buf_d = merged;
            cnt_d = total;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          emit       = 1'b1;
          emit_bytes = cnt_q;
          o_tdata_d  = buf_q[DATA_WIDTH-1:0];
          o_tkeep_d  = keep_mask(cnt_q);
          o_tlast_d  = 1'b1;
          buf_d      = '0;
          cnt_d      = '0;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (emit) begin
      o_valid_d = 1'b1;
      if (o_tlast_d) begin
        pb_d  = acc_q + 32'(emit_bytes);
        acc_d = '0;
      end else begin
        acc_d = acc_q + 32'(emit_bytes);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      buf_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      pb_q      <= '0;
      o_valid_q <= 1'b0;
      o_tdata_q <= '0;
      o_tkeep_q <= '0;
      o_tlast_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      pb_q      <= pb_d;
      o_valid_q <= o_valid_d;
      o_tdata_q <= o_tdata_d;
      o_tkeep_q <= o_tkeep_d;
      o_tlast_q <= o_tlast_d;
    end
  end

  assign o_data.aclk   = clk;
  assign o_data.tvalid = o_valid_q;
  assign o_data.tdata  = o_tdata_q;
  assign o_data.tkeep  = o_tkeep_q;
  assign o_data.tlast  = o_tlast_q;
  assign packet_bytes  = pb_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Scoreboard bench for axis_byte_packer at DATA_WIDTH = 32.
module tb_axis_byte_packer;

  localparam int DW = 32;
  localparam int NB = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
    logic [31:0]   pbytes;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] packet_bytes;

  axi4s_if #(.DATA_WIDTH(DW)) in_if ();
  axi4s_if #(.DATA_WIDTH(DW)) out_if ();

  assign in_if.aclk = clk;
  always #5 clk = ~clk;

  axis_byte_packer #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data       (in_if.s),
    .o_data       (out_if.m),
    .packet_bytes (packet_bytes)
  );

  beat_t      exp_q[$];
  logic [7:0] pend[$];
  int         pkt_len   = 0;
  int         errors    = 0;
  int         checks    = 0;
  int         ready_pct = 100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] mask_of(input int n);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [DW-1:0] lanes(input logic [NB-1:0] keep);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) if (keep[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Reference: the packet is a byte stream cut into NB-byte words as soon as
  // enough bytes exist; at tlast whatever remains (possibly nothing) closes
  // the packet unless the final full word already carried tlast.
  task automatic model_beat(input logic [DW-1:0] data, input int k, input logic last);
    beat_t b;
    bit    last_done;
    last_done = 0;
    for (int i = 0; i < k; i++) pend.push_back(data[i*8 +: 8]);
    pkt_len += k;
    while (pend.size() >= NB) begin
      b.data = '0;
      for (int i = 0; i < NB; i++) b.data[i*8 +: 8] = pend.pop_front();
      b.keep   = '1;
      b.last   = last && (pend.size() == 0);
      b.pbytes = pkt_len;
      if (b.last) last_done = 1;
      exp_q.push_back(b);
    end
    if (last && !last_done) begin
      b.data = '0;
      b.keep = mask_of(pend.size());
      for (int i = 0; pend.size() > 0; i++) b.data[i*8 +: 8] = pend.pop_front();
      b.last   = 1'b1;
      b.pbytes = pkt_len;
      exp_q.push_back(b);
    end
    if (last) pkt_len = 0;
  endtask

  // Called and returns at negedge+1.
  task automatic send_beat(input logic [DW-1:0] data, input logic [NB-1:0] keep, input logic last);
    int n;
    bit ok;
    int k;
    n = 0;
    k = $countones(keep);
    assert (keep == mask_of(k)) else $error("non-contiguous tkeep 0x%0h", keep);
    in_if.tvalid = 1'b1;
    in_if.tdata  = data;
    in_if.tkeep  = keep;
    in_if.tlast  = last;
    forever begin
      ok = in_if.tready;
      @(posedge clk);
      if (ok) break;
      n++;
      if (n > 2000) begin
        errors++;
        checks++;
        $display("FAIL in_accept_timeout: beat not accepted after %0d cycles", n);
        break;
      end
      @(negedge clk);
      #1;
    end
    if (ok) model_beat(data, k, last);
    @(negedge clk);
    #1;
    in_if.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      idle(1);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin : monitor
    bit    stall_prev;
    beat_t held;
    beat_t b;
    stall_prev      = 0;
    out_if.tready   = 1'b0;
    forever begin
      @(negedge clk);
      out_if.tready = ($urandom_range(99) < ready_pct);
      #1;
      if (!rst_n) begin
        stall_prev = 0;
        continue;
      end
      if (stall_prev) begin
        check("stall_tvalid", out_if.tvalid, 1);
        check("stall_tdata", out_if.tdata, held.data);
        check("stall_tkeep", out_if.tkeep, held.keep);
        check("stall_tlast", out_if.tlast, held.last);
      end
      if (out_if.tvalid && out_if.tready) begin
        stall_prev = 0;
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_beat: data 0x%0h keep 0x%0h last %0d with empty scoreboard",
                   out_if.tdata, out_if.tkeep, out_if.tlast);
        end else begin
          b = exp_q.pop_front();
          check("out_tkeep", out_if.tkeep, b.keep);
          check("out_tdata", out_if.tdata & lanes(b.keep), b.data);
          check("out_tlast", out_if.tlast, b.last);
          if (b.last) check("packet_bytes", packet_bytes, b.pbytes);
        end
      end else if (out_if.tvalid) begin
        stall_prev = 1;
        held.data  = out_if.tdata;
        held.keep  = out_if.tkeep;
        held.last  = out_if.tlast;
      end else begin
        stall_prev = 0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n        = 1'b0;
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tkeep  = '0;
    in_if.tlast  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_tvalid", out_if.tvalid, 0);
    check("rst_tdata", out_if.tdata, 0);
    check("rst_tkeep", out_if.tkeep, 0);
    check("rst_tlast", out_if.tlast, 0);
    check("rst_packet_bytes", packet_bytes, 0);
    check("rst_in_tready", in_if.tready, 1);
    #2 rst_n = 1'b1;
    idle(1);

    // Four half-filled beats pack into two full words.
    send_beat(32'h0000_0201, 4'h3, 1'b0);
    send_beat(32'h0000_0403, 4'h3, 1'b0);
    send_beat(32'h0000_0605, 4'h3, 1'b0);
    send_beat(32'h0000_0807, 4'h3, 1'b1);
    drain();
    check("t1_packet_bytes", packet_bytes, 8);

    // Residue after tlast forces a FLUSH cycle with tready low.
    send_beat(32'h0003_0201, 4'h7, 1'b0);
    send_beat(32'h0006_0504, 4'h7, 1'b1);
    check("flush_tready_low", in_if.tready, 0);
    idle(1);
    check("flush_tready_back", in_if.tready, 1);
    drain();
    check("t2_packet_bytes", packet_bytes, 6);

    // Empty tlast beat after an exact word.
    send_beat(32'hDDCC_BBAA, 4'hF, 1'b0);
    send_beat(32'h1234_5678, 4'h0, 1'b1);
    drain();
    check("t3_packet_bytes", packet_bytes, 4);

    // Zero-keep beats in the middle are absorbed.
    send_beat(32'h0000_0011, 4'h1, 1'b0);
    send_beat(32'hFFFF_FFFF, 4'h0, 1'b0);
    send_beat(32'hEEEE_EEEE, 4'h0, 1'b0);
    send_beat(32'h0000_0022, 4'h1, 1'b1);
    drain();
    check("t5_packet_bytes", packet_bytes, 2);

    // Random packets under 30% output ready.
    ready_pct = 30;
    for (int p = 0; p < 1000; p++) begin
      int nbeats;
      nbeats = $urandom_range(6, 1);
      for (int b = 0; b < nbeats; b++) begin
        send_beat($urandom, mask_of($urandom_range(NB, 0)), b == nbeats - 1);
        if ($urandom_range(7) == 0) idle(1);
      end
    end
    drain();

    // Reset mid-packet with a stalled output beat and residue of 3.
    ready_pct = 0;
    idle(2);
    send_beat(32'h0033_2211, 4'h7, 1'b0);
    send_beat(32'h7766_5544, 4'hF, 1'b0);
    idle(1);
    check("pre_rst_tvalid", out_if.tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", out_if.tvalid, 0);
    check("mid_rst_tdata", out_if.tdata, 0);
    check("mid_rst_tkeep", out_if.tkeep, 0);
    check("mid_rst_tlast", out_if.tlast, 0);
    check("mid_rst_packet_bytes", packet_bytes, 0);
    exp_q.delete();
    pend.delete();
    pkt_len = 0;
    ready_pct = 100;
    @(negedge clk);
    #3 rst_n = 1'b1;
    idle(1);
    send_beat(32'h0000_BBAA, 4'h3, 1'b1);
    drain();
    check("post_rst_packet_bytes", packet_bytes, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
